// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states, PC source select
// and inter-stage buffer indices.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_INT_DRAIN = 2'd1,
    ST_INT_VEC   = 2'd2,
    ST_HALTED    = 2'd3
  } seq_state_e;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_VEC = 2'b10;

  localparam int IFID  = 0;
  localparam int IDEX  = 1;
  localparam int EXMEM = 2;
  localparam int MEMWB = 3;

  localparam logic [3:0] BUF_ALL  = 4'b1111;
  localparam logic [3:0] BUF_NONE = 4'b0000;

  function automatic logic [3:0] buf_bit(input int idx);
    logic [3:0] mask;
    mask      = BUF_NONE;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect #(
  parameter int REG_ADDR_W = 3
) (
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  output logic                  hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = rs1_used && (rs1_addr == ex_rd_addr);
  assign rs2_hit = rs2_used && (rs2_addr == ex_rd_addr);
  assign hazard  = ex_mem_read && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_sequencer.sv
// Stall/flush/sequence controller for the five-stage pipeline; outputs are
// combinational from state and inputs, state advances on posedge.
//
// state        | meaning
// RUN          | normal issue; branch, load-use, interrupt and halt handled here
// INT_DRAIN    | PC frozen, bubbles fed into ID while older instructions retire
// INT_VEC      | one cycle: load interrupt vector into PC, acknowledge request
// HALTED       | HLT executed; pipeline drains, only an interrupt wakes it
module pipe_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int INT_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  id_halt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  input  logic                  int_req,
  output logic                  pc_we,
  output logic [1:0]            pc_sel,
  output logic [3:0]            buf_we,
  output logic [3:0]            buf_flush,
  output logic                  int_ack,
  output logic                  halted,
  output logic [1:0]            state
);

  localparam int CNT_W = $clog2(INT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INT_CYCLES - 1);

  seq_state_e       cur_state;
  seq_state_e       nxt_state;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             hazard;

  load_use_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_load_use (
    .ex_mem_read(ex_mem_read),
    .ex_rd_addr (ex_rd_addr),
    .rs1_addr   (id_rs1_addr),
    .rs2_addr   (id_rs2_addr),
    .rs1_used   (id_rs1_used),
    .rs2_used   (id_rs2_used),
    .hazard     (hazard)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= ST_RUN;
      cnt_q     <= '0;
    end else begin
      cur_state <= nxt_state;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    cnt_d     = cnt_q;
    pc_we     = 1'b1;
    pc_sel    = PC_SEL_SEQ;
    buf_we    = BUF_ALL;
    buf_flush = BUF_NONE;
    int_ack   = 1'b0;
    halted    = (cur_state == ST_HALTED);

    if (!reset) begin
      // Buffer flush is wired to the buffer resets, so hold every stage clear.
      pc_we     = 1'b0;
      buf_we    = BUF_NONE;
      buf_flush = BUF_ALL;
      halted    = 1'b0;
    end else if (mem_busy) begin
      pc_we  = 1'b0;
      buf_we = BUF_NONE;
    end else begin
      case (cur_state)
        ST_RUN: begin
          if (ex_branch_taken) begin
            pc_sel    = PC_SEL_BR;
            buf_flush = buf_bit(IFID) | buf_bit(IDEX);
          end else if (hazard) begin
            pc_we     = 1'b0;
            buf_we    = BUF_ALL & ~buf_bit(IFID);
            buf_flush = buf_bit(IDEX);
          end else if (int_req) begin
            pc_we     = 1'b0;
            buf_flush = buf_bit(IFID);
            nxt_state = ST_INT_DRAIN;
            cnt_d     = CNT_LOAD;
          end else if (id_halt) begin
            pc_we     = 1'b0;
            buf_flush = buf_bit(IFID);
            nxt_state = ST_HALTED;
          end
        end
        ST_INT_DRAIN: begin
          pc_we     = 1'b0;
          buf_flush = buf_bit(IFID);
          if (ex_branch_taken) begin
            // Redirect only; the drain schedule keeps running.
            pc_we     = 1'b1;
            pc_sel    = PC_SEL_BR;
            buf_flush = buf_bit(IFID) | buf_bit(IDEX);
          end
          if (cnt_q == '0) begin
            nxt_state = ST_INT_VEC;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_INT_VEC: begin
          pc_sel    = PC_SEL_VEC;
          int_ack   = 1'b1;
          buf_flush = buf_bit(IFID);
          nxt_state = ST_RUN;
        end
        ST_HALTED: begin
          pc_we     = 1'b0;
          buf_flush = buf_bit(IFID);
          if (int_req) begin
            nxt_state = ST_INT_DRAIN;
            cnt_d     = CNT_LOAD;
          end
        end
        default: nxt_state = ST_RUN;
      endcase
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_pipe_sequencer;

  localparam int RW = 3;
  localparam int IC = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [RW-1:0] id_rs1_addr = '0;
  logic [RW-1:0] id_rs2_addr = '0;
  logic          id_rs1_used = 1'b0;
  logic          id_rs2_used = 1'b0;
  logic          id_halt = 1'b0;
  logic          ex_mem_read = 1'b0;
  logic [RW-1:0] ex_rd_addr = '0;
  logic          ex_branch_taken = 1'b0;
  logic          mem_busy = 1'b0;
  logic          int_req = 1'b0;
  logic          pc_we;
  logic [1:0]    pc_sel;
  logic [3:0]    buf_we;
  logic [3:0]    buf_flush;
  logic          int_ack;
  logic          halted;
  logic [1:0]    state;

  pipe_sequencer #(.REG_ADDR_W(RW), .INT_CYCLES(IC)) dut (
    .clk(clk), .reset(reset),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_halt(id_halt), .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .int_req(int_req),
    .pc_we(pc_we), .pc_sel(pc_sel), .buf_we(buf_we), .buf_flush(buf_flush),
    .int_ack(int_ack), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   md = 0;       // model mode: 0 run, 1 draining, 2 vectoring, 3 halted
  int   drained = 0;  // drain cycles completed since entering the drain
  logic ack_seen = 1'b0;

  function automatic logic [14:0] pack(input int st, input int h, input int ack,
                                       input int pw, input int sel,
                                       input logic [3:0] we, input logic [3:0] fl);
    return {2'(st), 1'(h), 1'(ack), 1'(pw), 2'(sel), we, fl};
  endfunction

  function automatic logic [14:0] got_vec();
    return {state, halted, int_ack, pc_we, pc_sel, buf_we, buf_flush};
  endfunction

  task automatic chk(input string nm, input logic [14:0] exp);
    logic [14:0] g;
    g = got_vec();
    checks++;
    if (g !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got={st,h,ack,pcwe,sel,we,fl}=%h expected=%h", nm, $time, g, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int g, input int exp);
    checks++;
    if (g != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, g, exp);
    end
  endtask

  // Behavioural reference: every negedge, derive outputs from the rules.
  always @(negedge clk) begin : model
    logic hz;
    logic [14:0] e;
    int nmd;
    int nd;
    hz = ex_mem_read && ((id_rs1_used && id_rs1_addr == ex_rd_addr) ||
                         (id_rs2_used && id_rs2_addr == ex_rd_addr));
    nmd = md;
    nd  = drained;
    if (!reset) begin
      e = pack(0, 0, 0, 0, 0, 4'h0, 4'hf);
      nmd = 0;
      nd = 0;
    end else if (mem_busy) begin
      e = pack(md, (md == 3), 0, 0, 0, 4'h0, 4'h0);
    end else begin
      case (md)
        0: begin
          if (ex_branch_taken) e = pack(0, 0, 0, 1, 1, 4'hf, 4'h3);
          else if (hz) e = pack(0, 0, 0, 0, 0, 4'he, 4'h2);
          else if (int_req) begin
            e = pack(0, 0, 0, 0, 0, 4'hf, 4'h1);
            nmd = 1;
            nd = 0;
          end else if (id_halt) begin
            e = pack(0, 0, 0, 0, 0, 4'hf, 4'h1);
            nmd = 3;
          end else e = pack(0, 0, 0, 1, 0, 4'hf, 4'h0);
        end
        1: begin
          e = ex_branch_taken ? pack(1, 0, 0, 1, 1, 4'hf, 4'h3)
                              : pack(1, 0, 0, 0, 0, 4'hf, 4'h1);
          nd = drained + 1;
          if (nd == IC) nmd = 2;
        end
        2: begin
          e = pack(2, 0, 1, 1, 2, 4'hf, 4'h1);
          nmd = 0;
        end
        default: begin
          e = pack(3, 1, 0, 0, 0, 4'hf, 4'h1);
          if (int_req) begin
            nmd = 1;
            nd = 0;
          end
        end
      endcase
    end
    chk("cycle", e);
    md = nmd;
    drained = nd;
    ack_seen = int_ack;
  end

  always @(negedge reset) begin
    md = 0;
    drained = 0;
  end

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    id_halt = 1'b0; ex_mem_read = 1'b0; ex_rd_addr = '0; ex_branch_taken = 1'b0;
    mem_busy = 1'b0; int_req = 1'b0;
  endtask

  logic [14:0] norm_o, drain_o, vec_o, halt_o, entry_o;

  initial begin
    int got_ack;
    int ack_at;
    norm_o  = pack(0, 0, 0, 1, 0, 4'hf, 4'h0);
    entry_o = pack(0, 0, 0, 0, 0, 4'hf, 4'h1);
    drain_o = pack(1, 0, 0, 0, 0, 4'hf, 4'h1);
    vec_o   = pack(2, 0, 1, 1, 2, 4'hf, 4'h1);
    halt_o  = pack(3, 1, 0, 0, 0, 4'hf, 4'h1);
    clear_in();
    #1 chk("reset_state", pack(0, 0, 0, 0, 0, 4'h0, 4'hf));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    mid(); chk("norm_after_reset", norm_o);

    // Load-use on rs2, then cleared.
    nxt(); ex_mem_read = 1; ex_rd_addr = 3; id_rs2_addr = 3; id_rs2_used = 1;
    id_rs1_addr = 5; id_rs1_used = 1;
    mid(); chk("load_use", pack(0, 0, 0, 0, 0, 4'he, 4'h2));
    nxt(); clear_in();
    mid(); chk("load_use_cleared", norm_o);

    // Branch beats load-use.
    nxt(); ex_mem_read = 1; ex_rd_addr = 3; id_rs2_addr = 3; id_rs2_used = 1;
    ex_branch_taken = 1;
    mid(); chk("branch_over_load_use", pack(0, 0, 0, 1, 1, 4'hf, 4'h3));

    // Plain interrupt entry.
    nxt(); clear_in(); int_req = 1;
    mid(); chk("int_entry", entry_o);
    for (int i = 0; i < IC; i++) begin
      nxt(); mid(); chk("int_drain", drain_o);
    end
    nxt(); mid(); chk("int_vec", vec_o);
    nxt(); int_req = 0;
    mid(); chk("int_return", norm_o);

    // Interrupt with two busy cycles inside the drain.
    nxt(); int_req = 1;
    got_ack = 0;
    ack_at = -1;
    for (int c = 0; c < 20 && got_ack == 0; c++) begin
      mem_busy = (c == 2 || c == 3);
      mid();
      if (mem_busy) chk("busy_freeze", pack(1, 0, 0, 0, 0, 4'h0, 4'h0));
      if (int_ack) begin
        got_ack = 1;
        ack_at = c;
      end
      nxt();
    end
    int_req = 0; mem_busy = 0;
    chk_int("busy_stretch_ack_cycle", ack_at, 6);
    mid(); chk("busy_return", norm_o);

    // Halt, sit in HALTED, wake by interrupt.
    nxt(); id_halt = 1;
    mid(); chk("halt_entry", entry_o);
    nxt(); id_halt = 0;
    for (int i = 0; i < 10; i++) begin
      mid(); chk("halted_hold", halt_o); nxt();
    end
    int_req = 1;
    mid(); chk("halted_int_seen", halt_o);
    for (int i = 0; i < IC; i++) begin
      nxt(); mid(); chk("halt_drain", drain_o);
    end
    nxt(); mid(); chk("halt_vec", vec_o);
    nxt(); int_req = 0;
    mid(); chk("halt_exit", norm_o);

    // Branch on the second drain cycle keeps the schedule.
    nxt(); int_req = 1;
    mid(); chk("br_int_entry", entry_o);
    nxt(); mid(); chk("br_drain1", drain_o);
    nxt(); ex_branch_taken = 1;
    mid(); chk("drain_branch", pack(1, 0, 0, 1, 1, 4'hf, 4'h3));
    nxt(); ex_branch_taken = 0;
    mid(); chk("br_drain3", drain_o);
    nxt(); mid(); chk("br_vec", vec_o);
    nxt(); int_req = 0;
    mid(); chk("br_return", norm_o);

    // Async reset in the middle of the drain (count at 1).
    nxt(); int_req = 1;
    mid();
    nxt(); mid();
    nxt(); mid(); chk("pre_reset_drain", drain_o);
    reset = 1'b0; int_req = 0;
    #1 chk("reset_async", pack(0, 0, 0, 0, 0, 4'h0, 4'hf));
    nxt(); reset = 1'b1;
    mid(); chk("post_reset_norm", norm_o);

    // Randomized traffic checked by the model process.
    for (int n = 0; n < 3000; n++) begin
      nxt();
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 299) == 0) reset = 1'b0;
      mem_busy        = ($urandom_range(0, 4) == 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      ex_rd_addr      = 3'($urandom_range(0, 7));
      id_rs1_addr     = 3'($urandom_range(0, 7));
      id_rs2_addr     = 3'($urandom_range(0, 7));
      id_rs1_used     = 1'($urandom_range(0, 1));
      id_rs2_used     = 1'($urandom_range(0, 1));
      id_halt         = ($urandom_range(0, 14) == 0);
      if (!reset || ack_seen) int_req = 1'b0;
      else if (!int_req && $urandom_range(0, 29) == 0) int_req = 1'b1;
    end
    nxt(); clear_in(); reset = 1'b1;
    repeat (2) nxt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t expected completion earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_sequencer.md
Name: pipe_sequencer

Overview:
Central stall/flush/sequence controller for the five-stage pipeline. Drives write-enable and flush (zeroing) of the four inter-stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
Handles load-use stalls, taken-branch flushes, memory-busy freezes, the interrupt entry sequence and HLT.
All outputs are combinational from state plus inputs. They settle after posedge and before the negedge on which the buffers write. State updates on posedge.

Parameters:
REG_ADDR_W, 3, register-file address width (8 registers)
INT_CYCLES, 3, drain cycles before vectoring on an interrupt (>=1)

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
id_rs1_addr  in  REG_ADDR_W  ID source 1
id_rs2_addr  in  REG_ADDR_W  ID source 2
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
id_halt  in  1  HLT decoded in ID
ex_mem_read  in  1  EX instruction is a load
ex_rd_addr  in  REG_ADDR_W  EX destination
ex_branch_taken  in  1  EX resolved a taken branch/jump
mem_busy  in  1  data memory not ready (level)
int_req  in  1  external interrupt request (level; held until int_ack)
pc_we  out  1  PC write enable
pc_sel  out  2  00 sequential, 01 branch target, 10 interrupt vector
buf_we  out  4  buffer write enables; bit0 IF/ID … bit3 MEM/WB
buf_flush  out  4  buffer zero/bubble (wired to buffer reset); overrides buf_we
int_ack  out  1  one-cycle interrupt acknowledge
halted  out  1  high in HALTED
state  out  2  debug state encoding

Behaviour:
- States: RUN=0, INT_DRAIN=1, INT_VEC=2, HALTED=3. Drain counter cnt has width clog2(INT_CYCLES+1).
- Reset low (async, any time, including mid-sequence):
  - state=RUN, cnt=0.
  - Outputs forced: pc_we=0, buf_we=0000, buf_flush=1111, pc_sel=00, int_ack=0, halted=0.
- Default output set ("NORM"): pc_we=1, pc_sel=00, buf_we=1111, buf_flush=0000, int_ack=0.
- Per-cycle priority: mem_busy > ex_branch_taken > load-use > int_req > id_halt.
- mem_busy=1, any state:
  - pc_we=0, buf_we=0000, buf_flush=0000, int_ack=0.
  - state and cnt hold; no other input is acted on.
  - halted still reflects state.
- Taken branch (RUN or INT_DRAIN): pc_sel=01, pc_we=1, buf_we=1111, buf_flush=0011; state unchanged.
- Load-use hazard is defined as ex_mem_read & ((id_rs1_used & rs1==ex_rd) | (id_rs2_used & rs2==ex_rd)).
  - Acted on in RUN only: pc_we=0, buf_we=1110 (hold IF/ID), buf_flush=0010 (bubble into ID/EX).
  - Lasts exactly one cycle per hazard.
- RUN, int_req=1, no higher event:
  - Outputs: pc_we=0, buf_flush=0001, buf_we=1111.
  - Next: INT_DRAIN, cnt=INT_CYCLES-1.
- INT_DRAIN:
  - Outputs as on entry: pc_we=0, flush bit0.
  - cnt decrements each non-busy cycle. When cnt==0, next state is INT_VEC.
  - A taken branch during the drain redirects the PC and does not reset cnt.
- INT_VEC:
  - pc_sel=10, pc_we=1, int_ack=1, buf_we=1111, buf_flush=0001.
  - Next RUN. A branch here is ignored, because the ID/EX and EX stages are already bubbles.
- RUN, id_halt=1, no higher event: pc_we=0, buf_flush=0001; next HALTED.
- HALTED:
  - halted=1, pc_we=0, buf_we=1111, buf_flush=0001; the pipeline drains.
  - int_req=1 -> INT_DRAIN with cnt=INT_CYCLES-1.
  - Only reset or an interrupt exits HALTED.
- int_req is sampled in RUN and HALTED only. It is ignored in INT_DRAIN/INT_VEC, so no nesting.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encodings
  - PC_SEL_SEQ/PC_SEL_BR/PC_SEL_VEC
  - buffer index constants IFID=0, IDEX=1, EXMEM=2, MEMWB=3
- Sub-module load_use_detect: purely combinational comparator producing the hazard bit; parameterised on REG_ADDR_W.

Test Plan:
- Reset low mid-INT_DRAIN (cnt=1) -> immediately state=0, buf_flush=1111, pc_we=0; after release and the first posedge, NORM outputs.
- ex_mem_read=1, ex_rd=3, id_rs2=3, id_rs2_used=1 for one cycle -> pc_we=0, buf_we=1110, buf_flush=0010; next cycle (hazard cleared) NORM.
- Same cycle ex_branch_taken=1 and load-use -> pc_sel=01, buf_flush=0011, pc_we=1 (branch wins).
- int_req=1 in RUN, INT_CYCLES=3 -> 1 entry cycle, then 3 INT_DRAIN cycles (state 1, pc_we=0), then 1 INT_VEC (pc_sel=10, int_ack=1), then RUN. Repeat with mem_busy=1 for 2 cycles mid-drain -> sequence stretched by exactly 2 cycles, all buf_we=0 during those cycles.
- id_halt=1 -> HALTED, halted=1 persists for 10 cycles. Then int_req=1 -> INT_DRAIN, then INT_VEC with int_ack=1, then RUN with halted=0.
- ex_branch_taken=1 during the second INT_DRAIN cycle -> pc_sel=01, pc_we=1, flush=0011 that cycle; INT_VEC still reached on schedule.
